// File: rtl/text_write_ctrl.sv
// Character-RAM write sequencer for the keyboard-to-VGA text terminal.
// Cursor tracking, single-cell writes, screen and line clear fills.
module text_write_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30,
  parameter int XW   = 7,
  parameter int YW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_char,
  output logic          in_ready,
  output logic          ram_we,
  output logic [XW-1:0] ram_x,
  output logic [YW-1:0] ram_y,
  output logic [7:0]    ram_data,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          busy
);

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    LINE_CLR = 2'd2
  } state_t;

  localparam logic [XW-1:0] XMAX  = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX  = YW'(ROWS - 1);
  localparam logic [XW-1:0] XONE  = XW'(1);
  localparam logic [YW-1:0] YONE  = YW'(1);
  localparam logic [7:0]    SPACE = 8'h20;

  state_t        state_q, state_d;
  logic [XW-1:0] fx_q, fx_d;
  logic [YW-1:0] fy_q, fy_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic          we_q, we_d;
  logic [XW-1:0] rx_q, rx_d;
  logic [YW-1:0] ry_q, ry_d;
  logic [7:0]    rd_q, rd_d;

  logic acc;
  logic is_prt;
  logic is_nl;
  logic is_bs;
  logic is_ff;
  logic nl;

  assign acc    = in_valid && (state_q == IDLE);
  assign is_prt = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign is_nl  = (in_char == 8'h0D) || (in_char == 8'h0A);
  assign is_bs  = (in_char == 8'h08);
  assign is_ff  = (in_char == 8'h0C);

  // Next-state, cursor, fill counter and write-port decode
  always_comb begin
    state_d = state_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    we_d    = 1'b0;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rd_d    = rd_q;
    nl      = 1'b0;
    unique case (state_q)
      CLR_ALL: begin
        we_d = 1'b1;
        rx_d = fx_q;
        ry_d = fy_q;
        rd_d = SPACE;
        if (fx_q == XMAX) begin
          fx_d = '0;
          if (fy_q == YMAX) begin
            fy_d    = '0;
            state_d = IDLE;
          end else begin
            fy_d = fy_q + YONE;
          end
        end else begin
          fx_d = fx_q + XONE;
        end
      end
      LINE_CLR: begin
        we_d = 1'b1;
        rx_d = fx_q;
        ry_d = cy_q;
        rd_d = SPACE;
        if (fx_q == XMAX) begin
          fx_d    = '0;
          state_d = IDLE;
        end else begin
          fx_d = fx_q + XONE;
        end
      end
      IDLE: begin
        if (acc) begin
          unique case (1'b1)
            is_prt: begin
              we_d = 1'b1;
              rx_d = cx_q;
              ry_d = cy_q;
              rd_d = in_char;
              if (cx_q == XMAX) nl = 1'b1;
              else cx_d = cx_q + XONE;
            end
            is_nl: nl = 1'b1;
            is_bs: begin
              if (cx_q != '0) begin
                cx_d = cx_q - XONE;
                we_d = 1'b1;
                rx_d = cx_q - XONE;
                ry_d = cy_q;
                rd_d = SPACE;
              end else if (cy_q != '0) begin
                cx_d = XMAX;
                cy_d = cy_q - YONE;
                we_d = 1'b1;
                rx_d = XMAX;
                ry_d = cy_q - YONE;
                rd_d = SPACE;
              end
            end
            is_ff: begin
              cx_d    = '0;
              cy_d    = '0;
              fx_d    = '0;
              fy_d    = '0;
              state_d = CLR_ALL;
            end
            default: ;
          endcase
          if (nl) begin
            cx_d    = '0;
            cy_d    = (cy_q == YMAX) ? '0 : cy_q + YONE;
            fx_d    = '0;
            state_d = LINE_CLR;
          end
        end
      end
      default: begin
        fx_d    = '0;
        fy_d    = '0;
        state_d = CLR_ALL;
      end
    endcase
  end

  // State, cursor and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_ALL;
      fx_q    <= '0;
      fy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      we_q    <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      we_q    <= we_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rd_q    <= rd_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign ram_we   = we_q;
  assign ram_x    = rx_q;
  assign ram_y    = ry_q;
  assign ram_data = rd_q;
  assign cur_x    = cx_q;
  assign cur_y    = cy_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl.
// Writes are logged at the falling edge and checked against hand-built expectations.
module tb_text_write_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       ram_we;
  logic [6:0] ram_x;
  logic [4:0] ram_y;
  logic [7:0] ram_data;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [19:0] log_q[$];

  text_write_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_ready (in_ready),
    .ram_we   (ram_we),
    .ram_x    (ram_x),
    .ram_y    (ram_y),
    .ram_data (ram_data),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (ram_we) log_q.push_back({ram_x, ram_y, ram_data});
  endtask

  task automatic send(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!in_ready && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_cur(input string tag, input int x, input int y);
    chk({tag, "_cx"}, 32'(cur_x), 32'(x));
    chk({tag, "_cy"}, 32'(cur_y), 32'(y));
  endtask

  task automatic chk_wr(input string tag, input int x, input int y,
                        input int d);
    chk({tag, "_we"}, 32'(ram_we), 32'd1);
    chk({tag, "_x"}, 32'(ram_x), 32'(x));
    chk({tag, "_y"}, 32'(ram_y), 32'(y));
    chk({tag, "_d"}, 32'(ram_data), 32'(d));
  endtask

  task automatic chk_fill(input string tag, input int n);
    int errs;
    logic [19:0] e;
    errs = 0;
    chk({tag, "_cycles"}, 32'(n), 32'd2100);
    chk({tag, "_count"}, 32'(log_q.size()), 32'd2100);
    foreach (log_q[i]) begin
      e = {7'(i % 70), 5'(i / 70), 8'h20};
      if (log_q[i] !== e) errs++;
    end
    chk({tag, "_order"}, 32'(errs), 32'd0);
  endtask

  task automatic chk_line(input string tag, input int n, input int row);
    int errs;
    logic [19:0] e;
    errs = 0;
    chk({tag, "_cycles"}, 32'(n), 32'd70);
    chk({tag, "_count"}, 32'(log_q.size()), 32'd70);
    foreach (log_q[i]) begin
      e = {7'(i), 5'(row), 8'h20};
      if (log_q[i] !== e) errs++;
    end
    chk({tag, "_order"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;

    // 1: reset state, then power-up clear
    tick();
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_x", 32'(ram_x), 32'd0);
    chk("rst_y", 32'(ram_y), 32'd0);
    chk("rst_d", 32'(ram_data), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk_cur("rst", 0, 0);
    rst = 1'b0;
    log_q.delete();
    wait_idle(n);
    chk_wr("fill_last", 69, 29, 8'h20);
    chk_fill("fill1", n);
    tick();
    chk("idle_we", 32'(ram_we), 32'd0);
    chk("idle_rdy", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_hold_x", 32'(ram_x), 32'd69);

    // 2: single printable char
    send(8'h41);
    chk_wr("A", 0, 0, 8'h41);
    chk_cur("A", 1, 0);
    chk("A_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("A_we_drop", 32'(ram_we), 32'd0);

    // backspace with cur_x>0
    send(8'h08);
    chk_wr("bs1", 0, 0, 8'h20);
    chk_cur("bs1", 0, 0);

    // ignored code
    send(8'h07);
    chk("ign_we", 32'(ram_we), 32'd0);
    chk_cur("ign", 0, 0);
    chk("ign_rdy", 32'(in_ready), 32'd1);

    // 3: fill a row, wrap to row 1 with line clear
    log_q.delete();
    for (int i = 0; i < 69; i++) send(8'(8'h41 + i % 26));
    chk("row_count", 32'(log_q.size()), 32'd69);
    chk_cur("row69", 69, 0);
    send(8'h23);
    chk_wr("wrap", 69, 0, 8'h23);
    chk_cur("wrap", 0, 1);
    chk("wrap_rdy", 32'(in_ready), 32'd0);
    log_q.delete();
    wait_idle(n);
    chk_line("lc1", n, 1);

    // 5: backspace across a line boundary
    send(8'h08);
    chk_wr("bs_up", 69, 0, 8'h20);
    chk_cur("bs_up", 69, 0);
    for (int i = 0; i < 69; i++) send(8'h08);
    chk_cur("bs_home", 0, 0);
    send(8'h08);
    chk("bs00_we", 32'(ram_we), 32'd0);
    chk_cur("bs00", 0, 0);
    chk("bs00_rdy", 32'(in_ready), 32'd1);

    // 4: CR at the bottom row wraps to the top
    for (int i = 0; i < 29; i++) begin
      send(8'h0A);
      wait_idle(n);
    end
    chk_cur("lf29", 0, 29);
    for (int i = 0; i < 5; i++) send(8'h61);
    chk_cur("at5_29", 5, 29);
    send(8'h0D);
    chk("cr_we", 32'(ram_we), 32'd0);
    chk_cur("cr", 0, 0);
    chk("cr_rdy", 32'(in_ready), 32'd0);
    log_q.delete();
    wait_idle(n);
    chk_line("lc0", n, 0);

    // 6: reset in the middle of a line clear
    send(8'h0A);
    for (int i = 0; i < 30; i++) tick();
    chk_wr("lc_mid", 29, 1, 8'h20);
    rst = 1'b1;
    tick();
    chk("rst2_we", 32'(ram_we), 32'd0);
    chk_cur("rst2", 0, 0);
    chk("rst2_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    log_q.delete();
    wait_idle(n);
    chk_fill("fill2", n);

    // form feed restarts the full-screen clear
    send(8'h61);
    send(8'h0C);
    chk("ff_we", 32'(ram_we), 32'd0);
    chk_cur("ff", 0, 0);
    chk("ff_rdy", 32'(in_ready), 32'd0);
    log_q.delete();
    wait_idle(n);
    chk_fill("fill3", n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
